// File: rtl/gpio_xfer.sv
// ---------------------------------------------------------------------------
// gpio_xfer
//
// Transaction sequencer sitting directly upstream of the 32-bit bidirectional
// GPIO pad buffer. It takes one write or read request at a time from an
// internal master and turns it into a pad-level sequence:
//   write: raise gpio_oe, wait TURN_CYC cycles for the pad buffer's direction
//          pipeline, pulse gpio_strobe for HOLD_CYC cycles, hold the data one
//          more cycle, drop gpio_oe and wait TURN_CYC cycles so the pads are
//          tri-stated before anything else can happen, then respond.
//   read:  pulse gpio_strobe for HOLD_CYC cycles with gpio_oe low, sample the
//          pad word on the last strobe cycle, then respond.
//
// Parameters:
//   TURN_CYC  direction turnaround length in cycles (2..255)
//   HOLD_CYC  strobe high width in cycles (1..255)
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   req_valid    request present
//   req_ready    block idle; request taken when req_valid & req_ready
//   req_write    1 = write, 0 = read, sampled at accept
//   req_data     write data, sampled at accept for writes
//   rsp_valid    one-cycle completion pulse
//   rsp_data     read data, valid with rsp_valid after a read
//   gpio_in      data word to the pad buffer
//   gpio_oe      direction request to the pad buffer, 1 = drive pads
//   gpio_out     sampled pad word from the pad buffer
//   gpio_strobe  external transfer strobe
//   busy         inverse of req_ready
// ---------------------------------------------------------------------------
module gpio_xfer #(
  parameter int TURN_CYC = 3,
  parameter int HOLD_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [31:0] gpio_in,
  output logic        gpio_oe,
  input  logic [31:0] gpio_out,
  output logic        gpio_strobe,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_TURN = 3'd1,
    W_STRB = 3'd2,
    W_HOLD = 3'd3,
    W_REL  = 3'd4,
    R_STRB = 3'd5
  } state_t;

  // Each timed state is entered with (length - 1) and leaves on zero, so a
  // state loaded with N-1 occupies exactly N cycles.
  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       cnt_zero;
  logic       accept;

  assign cnt_zero = (cnt == 8'd0);
  assign accept   = req_valid & req_ready;

  // Single sequencer. Every output is a flop updated together with the state
  // transition that implies it, so req_ready/busy always agree with the state
  // and the pad-facing signals never glitch. The async reset clears gpio_oe
  // immediately, releasing the pads even in the middle of a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      gpio_oe     <= 1'b0;
      gpio_strobe <= 1'b0;
      gpio_in     <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 32'd0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_write) begin
              gpio_in <= req_data;
              gpio_oe <= 1'b1;
              cnt     <= TURN_LOAD;
              state   <= W_TURN;
            end else begin
              gpio_strobe <= 1'b1;
              cnt         <= HOLD_LOAD;
              state       <= R_STRB;
            end
          end
        end

        W_TURN: begin
          if (cnt_zero) begin
            gpio_strobe <= 1'b1;
            cnt         <= HOLD_LOAD;
            state       <= W_STRB;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        W_STRB: begin
          if (cnt_zero) begin
            gpio_strobe <= 1'b0;
            state       <= W_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        // One extra cycle of data hold after the strobe falls.
        W_HOLD: begin
          gpio_oe <= 1'b0;
          cnt     <= TURN_LOAD;
          state   <= W_REL;
        end

        // Pads are being released; no new request until the buffer is off.
        W_REL: begin
          if (cnt_zero) begin
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        // The pad word is captured on the edge that ends the last strobe cycle.
        R_STRB: begin
          if (cnt_zero) begin
            rsp_data    <= gpio_out;
            gpio_strobe <= 1'b0;
            rsp_valid   <= 1'b1;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= 8'd0;
          gpio_oe     <= 1'b0;
          gpio_strobe <= 1'b0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_xfer.sv
// ---------------------------------------------------------------------------
// tb_gpio_xfer
//
// Bench for gpio_xfer. One instance uses the default timing (TURN=3, HOLD=4),
// a second one uses the short timing (TURN=2, HOLD=1). Expected behaviour is
// derived from the cycle timing of a transaction counted from its accept edge.
// ---------------------------------------------------------------------------
module tb_gpio_xfer;

  localparam int TURN   = 3;
  localparam int HOLD   = 4;
  localparam int S_TURN = 2;
  localparam int S_HOLD = 1;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] gpio_in;
  logic        gpio_oe;
  logic [31:0] gpio_out;
  logic        gpio_strobe;
  logic        busy;

  logic        s_req_valid;
  logic        s_req_ready;
  logic        s_req_write;
  logic [31:0] s_req_data;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_data;
  logic [31:0] s_gpio_in;
  logic        s_gpio_oe;
  logic [31:0] s_gpio_out;
  logic        s_gpio_strobe;
  logic        s_busy;

  int total = 0;
  int bad   = 0;

  // Reference state: last word written and last word read back.
  logic [31:0] last_in;
  logic [31:0] last_rsp;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    logic [31:0] pad;
    logic [31:0] exp_in;
    logic [31:0] exp_rsp;
    int          exp_len;
  } vec_t;

  vec_t vecs[5];

  gpio_xfer #(.TURN_CYC(TURN), .HOLD_CYC(HOLD)) u_dut (
    .clk         (clk),
    .reset       (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .gpio_in     (gpio_in),
    .gpio_oe     (gpio_oe),
    .gpio_out    (gpio_out),
    .gpio_strobe (gpio_strobe),
    .busy        (busy)
  );

  gpio_xfer #(.TURN_CYC(S_TURN), .HOLD_CYC(S_HOLD)) u_small (
    .clk         (clk),
    .reset       (reset_n),
    .req_valid   (s_req_valid),
    .req_ready   (s_req_ready),
    .req_write   (s_req_write),
    .req_data    (s_req_data),
    .rsp_valid   (s_rsp_valid),
    .rsp_data    (s_rsp_data),
    .gpio_in     (s_gpio_in),
    .gpio_oe     (s_gpio_oe),
    .gpio_out    (s_gpio_out),
    .gpio_strobe (s_gpio_strobe),
    .busy        (s_busy)
  );

  always #5 clk = ~clk;

  // Safety net in case something hangs despite the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Number of non-IDLE cycles of a transaction.
  function automatic int txn_len(input bit wr, input int t, input int h);
    return wr ? (2 * t + h + 1) : h;
  endfunction

  // Expected control outputs in cycle k after the accept edge (edge 0).
  function automatic void model_cycle(input bit wr, input int k, input int t,
                                      input int h, output bit oe, output bit stb,
                                      output bit rv, output bit rdy);
    int len;
    len = txn_len(wr, t, h);
    rdy = !(k >= 1 && k <= len);
    rv  = (k == len + 1);
    if (wr) begin
      oe  = (k >= 1) && (k <= t + h + 1);
      stb = (k >= t + 1) && (k <= t + h);
    end else begin
      oe  = 1'b0;
      stb = (k >= 1) && (k <= h);
    end
  endfunction

  task automatic check_ctrl(input string tag, input bit wr, input int k);
    bit oe, stb, rv, rdy;
    model_cycle(wr, k, TURN, HOLD, oe, stb, rv, rdy);
    check_bit({tag, "_oe"}, gpio_oe, oe);
    check_bit({tag, "_strobe"}, gpio_strobe, stb);
    check_bit({tag, "_rsp_valid"}, rsp_valid, rv);
    check_bit({tag, "_ready"}, req_ready, rdy);
    check_bit({tag, "_busy"}, busy, !rdy);
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) report_timeout({tag, "_wait_ready"});
  endtask

  // Runs one transaction on the main instance starting at a falling edge,
  // checks every cycle against the timing model, and updates the model state.
  // gpio_out carries the pad word only in the last strobe cycle of a read so
  // that sampling on any other edge is visible.
  task automatic apply_stimulus(input bit wr, input logic [31:0] data,
                                input logic [31:0] pad, input logic [31:0] exp_in,
                                input logic [31:0] exp_rsp, input int exp_len,
                                input string tag);
    bit ok;
    int len;
    int busy_cnt;
    wait_ready(tag, ok);
    if (!ok) return;
    len = txn_len(wr, TURN, HOLD);
    busy_cnt = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_data  = data;
    for (int k = 1; k <= len + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_data  = $urandom;
      end
      gpio_out = (!wr && k == HOLD) ? pad : ~pad;
      @(negedge clk);
      check_ctrl($sformatf("%s_c%0d", tag, k), wr, k);
      if (busy === 1'b1) busy_cnt++;
      check_output($sformatf("%s_c%0d_gpio_in", tag, k), gpio_in, wr ? data : last_in);
      check_output($sformatf("%s_c%0d_rsp_data", tag, k), rsp_data,
                   (!wr && k == len + 1) ? pad : last_rsp);
    end
    check_output({tag, "_busy_len"}, busy_cnt, exp_len);
    check_output({tag, "_final_gpio_in"}, gpio_in, exp_in);
    check_output({tag, "_final_rsp_data"}, rsp_data, exp_rsp);
    if (wr) last_in = data;
    else    last_rsp = pad;
  endtask

  // Back-to-back write then read with req_valid held high throughout.
  task automatic b2b_sequence();
    bit ok;
    bit strobe_seen;
    int lw;
    int last_oe;
    int total_k;
    logic [31:0] wdata;
    logic [31:0] pad;
    wdata = 32'hCAFE0001;
    pad   = 32'h0BADF00D;
    wait_ready("b2b", ok);
    if (!ok) return;
    lw = txn_len(1'b1, TURN, HOLD);
    total_k = lw + 1 + HOLD + 1;
    last_oe = 0;
    strobe_seen = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_data  = wdata;
    for (int k = 1; k <= total_k; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        req_write = 1'b0;
        req_data  = $urandom;
      end
      if (k == lw + 2) req_valid = 1'b0;
      gpio_out = (k == lw + 1 + HOLD) ? pad : ~pad;
      @(negedge clk);
      if (k <= lw + 1) check_ctrl($sformatf("b2b_w_c%0d", k), 1'b1, k);
      else             check_ctrl($sformatf("b2b_r_c%0d", k - lw - 1), 1'b0, k - lw - 1);
      check_output($sformatf("b2b_c%0d_gpio_in", k), gpio_in, wdata);
      check_output($sformatf("b2b_c%0d_rsp_data", k), rsp_data,
                   (k == total_k) ? pad : last_rsp);
      if (gpio_oe === 1'b1) last_oe = k;
      if (gpio_strobe === 1'b1 && k > lw + 1 && !strobe_seen) begin
        strobe_seen = 1'b1;
        check_bit("b2b_turnaround", (k - last_oe - 1) >= TURN, 1'b1);
      end
    end
    if (!strobe_seen) report_timeout("b2b_read_strobe");
    last_in  = wdata;
    last_rsp = pad;
  endtask

  // Reset pulled during the strobe phase of a write.
  task automatic reset_mid_write();
    bit ok;
    int rv_cnt;
    int nrdy_cnt;
    wait_ready("rst", ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_data  = 32'h5555AAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_bit("rst_pre_strobe", gpio_strobe, 1'b1);
    check_bit("rst_pre_oe", gpio_oe, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("rst_async_oe", gpio_oe, 1'b0);
    check_bit("rst_async_strobe", gpio_strobe, 1'b0);
    check_bit("rst_async_rsp_valid", rsp_valid, 1'b0);
    check_output("rst_async_gpio_in", gpio_in, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv_cnt = 0;
    nrdy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) rv_cnt++;
      if (req_ready !== 1'b1) nrdy_cnt++;
    end
    check_output("rst_no_rsp", rv_cnt, 0);
    check_output("rst_ready_after", nrdy_cnt, 0);
    last_in  = 32'd0;
    last_rsp = 32'd0;
  endtask

  // A one-cycle read request during a write must be dropped, not queued.
  task automatic busy_request_dropped();
    bit ok;
    int stb_cnt;
    int rv_cnt;
    int oe_cnt;
    logic [31:0] wdata;
    wdata = 32'h600DC0DE;
    wait_ready("drop", ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_data  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    stb_cnt = 0;
    rv_cnt  = 0;
    oe_cnt  = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (gpio_strobe === 1'b1) stb_cnt++;
      if (rsp_valid === 1'b1) rv_cnt++;
      if (gpio_oe === 1'b1) oe_cnt++;
      if (k == 3) begin
        check_bit("drop_ready_low", req_ready, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b0;
      end
      if (k == 4) req_valid = 1'b0;
    end
    check_output("drop_strobe_cycles", stb_cnt, HOLD);
    check_output("drop_rsp_count", rv_cnt, 1);
    check_output("drop_oe_cycles", oe_cnt, TURN + HOLD + 1);
    check_output("drop_gpio_in", gpio_in, wdata);
    check_output("drop_rsp_data", rsp_data, last_rsp);
    last_in = wdata;
  endtask

  // One transaction on the short-timing instance; measures the busy window.
  task automatic run_small(input bit wr, input logic [31:0] data,
                           input logic [31:0] pad, input int exp_busy,
                           input string tag);
    bit ok;
    bit done;
    int busy_cnt;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (s_req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      report_timeout({tag, "_wait_ready"});
      return;
    end
    s_req_valid = 1'b1;
    s_req_write = wr;
    s_req_data  = data;
    s_gpio_out  = pad;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    busy_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_busy === 1'b1) busy_cnt++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) report_timeout({tag, "_busy_end"});
    check_output({tag, "_busy_len"}, busy_cnt, exp_busy);
    check_bit({tag, "_rsp_valid"}, s_rsp_valid, 1'b1);
    if (wr) check_output({tag, "_gpio_in"}, s_gpio_in, data);
    else    check_output({tag, "_rsp_data"}, s_rsp_data, pad);
  endtask

  initial begin
    bit          wr;
    logic [31:0] data;
    logic [31:0] pad;

    vecs[0] = '{1'b1, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h00000000, 11};
    vecs[1] = '{1'b0, 32'h00000000, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 4};
    vecs[2] = '{1'b1, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h12345678, 11};
    vecs[3] = '{1'b0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 4};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00000000, 4};

    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_data    = 32'd0;
    gpio_out    = 32'd0;
    s_req_valid = 1'b0;
    s_req_write = 1'b0;
    s_req_data  = 32'd0;
    s_gpio_out  = 32'd0;
    last_in     = 32'd0;
    last_rsp    = 32'd0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_bit("reset_ready", req_ready, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_oe", gpio_oe, 1'b0);
    check_bit("reset_strobe", gpio_strobe, 1'b0);
    check_bit("reset_rsp_valid", rsp_valid, 1'b0);
    check_output("reset_gpio_in", gpio_in, 32'd0);
    check_output("reset_rsp_data", rsp_data, 32'd0);
    check_bit("reset_small_ready", s_req_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].data, vecs[i].pad, vecs[i].exp_in,
                     vecs[i].exp_rsp, vecs[i].exp_len, $sformatf("vec%0d", i));
    end

    b2b_sequence();
    busy_request_dropped();
    reset_mid_write();

    for (int i = 0; i < 30; i++) begin
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      pad  = $urandom;
      apply_stimulus(wr, data, pad, wr ? data : last_in, wr ? last_rsp : pad,
                     txn_len(wr, TURN, HOLD), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    run_small(1'b1, 32'h13579BDF, 32'h2468ACE0, 6, "small_wr");
    run_small(1'b0, 32'h00000000, 32'h2468ACE0, 1, "small_rd");
    run_small(1'b0, 32'h00000000, 32'hFEDCBA98, 1, "small_rd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_xfer.md
Name: gpio_xfer

Overview:
Transaction sequencer that sits directly upstream of the 32-bit bidirectional GPIO pad buffer. It drives that buffer's data word (gpio_in) and direction request (gpio_oe), and consumes its sampled pad word (gpio_out). It accepts single-word write and read requests from an internal master over a valid/ready handshake. For each request it produces direction turnaround, an external strobe pulse, data hold and read sampling, then returns a one-cycle response.

Parameters:
TURN_CYC, 3, cycles gpio_oe is held before the strobe (write) and after release (write end); must be >=2 to cover the pad buffer's 2-cycle direction pipeline; max 255
HOLD_CYC, 4, strobe high width in cycles for both reads and writes; must be >=1; max 255

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  input  1  request present
req_ready  output  1  block idle, request accepted when req_valid & req_ready
req_write  input  1  1 = write, 0 = read; sampled at accept
req_data  input  32  write data; sampled at accept when req_write=1
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  32  read data; valid with rsp_valid after a read
gpio_in  output  32  data word to pad buffer (drives pads when enabled)
gpio_oe  output  1  direction request to pad buffer, 1 = drive pads
gpio_out  input  32  pad word from pad buffer
gpio_strobe  output  1  external transfer strobe
busy  output  1  ~req_ready

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, gpio_oe=0, gpio_strobe=0, gpio_in=0, rsp_valid=0, rsp_data=0, req_ready=1 once released. Reset mid-transaction aborts immediately; no response is issued. The pads are released because gpio_oe drops asynchronously.
- All outputs are registered. req_ready=(state==IDLE). Requests while not ready are ignored and not queued.
- The 8-bit down-counter cnt is loaded on state entry and each state exits when cnt==0.
- IDLE: on accept with write=1, gpio_in<=req_data, gpio_oe<=1, cnt<=TURN_CYC-1, go to W_TURN. On accept with write=0, gpio_strobe<=1, cnt<=HOLD_CYC-1, go to R_STRB.
- W_TURN (TURN_CYC cycles, oe=1, strobe=0): on exit, gpio_strobe<=1, cnt<=HOLD_CYC-1, go to W_STRB.
- W_STRB (HOLD_CYC cycles, strobe=1): on exit, strobe<=0, go to W_HOLD.
- W_HOLD (1 cycle, oe=1, data held): then gpio_oe<=0, cnt<=TURN_CYC-1, go to W_REL.
- W_REL (TURN_CYC cycles, oe=0): lets the buffer tri-state before any read. On exit, rsp_valid<=1, go to IDLE.
- R_STRB (HOLD_CYC cycles, strobe=1, oe stays 0): on exit, rsp_data<=gpio_out (sampled on the final strobe cycle edge), strobe<=0, rsp_valid<=1, go to IDLE.
- Timing with accept edge at cycle 0:
  - gpio_oe is high in cycles 1..TURN_CYC+HOLD_CYC+1.
  - A write occupies 2*TURN_CYC+HOLD_CYC+1 non-IDLE cycles.
  - A read occupies HOLD_CYC non-IDLE cycles.
  - rsp_valid is high in the first IDLE cycle after a transaction.
- rsp_valid is high exactly 1 cycle.
- A new request may be accepted in the same cycle rsp_valid is high, so back-to-back transactions have no dead cycle.
- gpio_in retains the last written word after a write. Reads never modify gpio_in.
- rsp_data is unchanged by writes.
- gpio_oe is never high while state is in IDLE, R_STRB or W_REL.
- gpio_strobe is never high during W_TURN, W_HOLD or W_REL.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles, release. Required: req_ready=1, gpio_oe=0, gpio_strobe=0, gpio_in=0, rsp_valid=0.
2. Write 0xDEADBEEF with defaults (TURN=3, HOLD=4). Required:
   - gpio_in=0xDEADBEEF from cycle 1.
   - gpio_oe high cycles 1-8; strobe high cycles 4-7.
   - rsp_valid pulse at cycle 12.
   - req_ready low in cycles 1-11.
3. Read with gpio_out driven 0x12345678 during the strobe. Required:
   - strobe high cycles 1-4; gpio_oe stays 0.
   - rsp_valid at cycle 5 with rsp_data=0x12345678.
   - gpio_in unchanged.
4. Back-to-back write then read, req_valid held high. Required:
   - The read is accepted in the write's rsp_valid cycle.
   - The read strobe starts the next cycle with gpio_oe=0, and at least TURN_CYC cycles have elapsed since gpio_oe fell.
5. Reset asserted during W_STRB of a write. Required: gpio_oe and gpio_strobe drop to 0 immediately, no rsp_valid, and req_ready=1 after release.
6. Request asserted while busy. Required: it is not accepted until req_ready=1. Parameter sweep (TURN=2, HOLD=1): write busy = 6 cycles, read busy = 1 cycle.
